// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the DDR3 frame-buffer command arbiter.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam int BANK_W = 2;
    localparam int CNT_W  = 11;

    localparam int FB_ADDR_W       = 29;
    localparam int FB_BASE_ADDR    = 0;
    localparam int FB_FRAME_STRIDE = 32'h0080_0000;
    localparam int FB_BURST_STRIDE = 256;
    localparam int FB_BURST_WORDS  = 32;
    localparam int FB_FRAME_BURSTS = 1800;
    localparam int FB_LVL_W        = 10;
    localparam int FB_RD_URGENT    = 768;

endpackage

// File: rtl/fb_bank_sel.sv
// Triple-buffer helper: picks the lowest bank that is neither the newest complete frame nor on display.
module fb_bank_sel
    import fb_pkg::*;
(
    input  logic [BANK_W-1:0] latest,
    input  logic [BANK_W-1:0] rd_bank,
    output logic [BANK_W-1:0] free_bank
);

    always_comb begin
        free_bank = 2'd2;
        if (latest != 2'd0 && rd_bank != 2'd0) begin
            free_bank = 2'd0;
        end else if (latest != 2'd1 && rd_bank != 2'd1) begin
            free_bank = 2'd1;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Shares the DDR3 application command port between the video-in writer and video-out reader,
// one fixed-length burst in flight, over a tear-free triple frame buffer.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int BASE_ADDR    = FB_BASE_ADDR,
    parameter int FRAME_STRIDE = FB_FRAME_STRIDE,
    parameter int BURST_STRIDE = FB_BURST_STRIDE,
    parameter int BURST_WORDS  = FB_BURST_WORDS,
    parameter int FRAME_BURSTS = FB_FRAME_BURSTS,
    parameter int LVL_W        = FB_LVL_W,
    parameter int RD_URGENT    = FB_RD_URGENT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calib_done,
    input  logic              wr_frame_start,
    input  logic [LVL_W-1:0]  wr_level,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  rd_space,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic [10:0]       wr_burst_cnt,
    output logic [10:0]       rd_burst_cnt,
    output logic              busy
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BURSTS);

    state_t              state, state_n;
    logic                cmd_valid_n, cmd_write_n;
    logic [ADDR_W-1:0]   cmd_addr_n;
    logic [BANK_W-1:0]   wr_bank_n, rd_bank_n, latest, latest_n, free_bank;
    logic [CNT_W-1:0]    wr_burst_cnt_n, rd_burst_cnt_n;
    logic                wr_pend, wr_pend_n, rd_pend, rd_pend_n;
    logic                last_wr, last_wr_n;
    logic                done_seen, done_seen_n;
    logic                wreq, rreq, urgent, grant_rd, grant_wr;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [BANK_W-1:0] bank,
                                                     input logic [CNT_W-1:0]  cnt);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(bank) * ADDR_W'(FRAME_STRIDE)
             + ADDR_W'(cnt) * ADDR_W'(BURST_STRIDE);
    endfunction

    // Free bank for the writer once the current write bank becomes the newest frame.
    fb_bank_sel u_bank_sel (
        .latest    (wr_bank),
        .rd_bank   (rd_bank),
        .free_bank (free_bank)
    );

    assign wreq     = (wr_level >= LVL_W'(BURST_WORDS)) && (wr_burst_cnt < FRAME_CNT);
    assign rreq     = (rd_space >= LVL_W'(BURST_WORDS)) && (rd_burst_cnt < FRAME_CNT);
    assign urgent   = rreq && (rd_space >= LVL_W'(RD_URGENT));
    assign grant_rd = rreq && (urgent || !wreq || last_wr);
    assign grant_wr = wreq && !grant_rd;
    assign busy     = (state == ST_ISSUE) || (state == ST_WAIT);

    always_comb begin
        state_n        = state;
        cmd_valid_n    = cmd_valid;
        cmd_write_n    = cmd_write;
        cmd_addr_n     = cmd_addr;
        wr_bank_n      = wr_bank;
        rd_bank_n      = rd_bank;
        latest_n       = latest;
        wr_burst_cnt_n = wr_burst_cnt;
        rd_burst_cnt_n = rd_burst_cnt;
        wr_pend_n      = wr_pend | wr_frame_start;
        rd_pend_n      = rd_pend | rd_frame_start;
        last_wr_n      = last_wr;
        done_seen_n    = done_seen;

        if (!calib_done) begin
            state_n     = ST_INIT;
            cmd_valid_n = 1'b0;
            done_seen_n = 1'b0;
        end else begin
            case (state)
                ST_INIT: state_n = ST_ARB;
                ST_ARB: begin
                    if (wr_pend || rd_pend) begin
                        // Write side first so the reader picks up a frame completed this cycle.
                        if (wr_pend) begin
                            if (wr_burst_cnt == FRAME_CNT) begin
                                latest_n  = wr_bank;
                                wr_bank_n = free_bank;
                            end
                            wr_burst_cnt_n = '0;
                            wr_pend_n      = wr_frame_start;
                        end
                        if (rd_pend) begin
                            rd_bank_n      = latest_n;
                            rd_burst_cnt_n = '0;
                            rd_pend_n      = rd_frame_start;
                        end
                    end else if (grant_rd || grant_wr) begin
                        cmd_valid_n = 1'b1;
                        cmd_write_n = grant_wr;
                        cmd_addr_n  = grant_wr ? burst_addr(wr_bank, wr_burst_cnt)
                                               : burst_addr(rd_bank, rd_burst_cnt);
                        last_wr_n   = grant_wr;
                        done_seen_n = 1'b0;
                        state_n     = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    done_seen_n = done_seen | burst_done;
                    if (cmd_ready) begin
                        cmd_valid_n = 1'b0;
                        state_n     = ST_WAIT;
                        if (cmd_write && wr_burst_cnt < FRAME_CNT) begin
                            wr_burst_cnt_n = wr_burst_cnt + 11'd1;
                        end
                        if (!cmd_write && rd_burst_cnt < FRAME_CNT) begin
                            rd_burst_cnt_n = rd_burst_cnt + 11'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (burst_done || done_seen) begin
                        done_seen_n = 1'b0;
                        state_n     = ST_ARB;
                    end
                end
                default: state_n = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            cmd_valid    <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            wr_bank      <= 2'd0;
            rd_bank      <= 2'd1;
            latest       <= 2'd1;
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
            last_wr      <= 1'b0;
            done_seen    <= 1'b0;
        end else begin
            state        <= state_n;
            cmd_valid    <= cmd_valid_n;
            cmd_write    <= cmd_write_n;
            cmd_addr     <= cmd_addr_n;
            wr_bank      <= wr_bank_n;
            rd_bank      <= rd_bank_n;
            latest       <= latest_n;
            wr_burst_cnt <= wr_burst_cnt_n;
            rd_burst_cnt <= rd_burst_cnt_n;
            wr_pend      <= wr_pend_n;
            rd_pend      <= rd_pend_n;
            last_wr      <= last_wr_n;
            done_seen    <= done_seen_n;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a simple DDR IP responder plus arbitration vectors and frame-swap sequences.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst, calib_done, wr_frame_start, rd_frame_start;
    logic [9:0]  wr_level, rd_space;
    logic        cmd_valid, cmd_ready, cmd_write, burst_done, busy;
    logic [28:0] cmd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic [10:0] wr_burst_cnt, rd_burst_cnt;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .calib_done     (calib_done),
        .wr_frame_start (wr_frame_start),
        .wr_level       (wr_level),
        .rd_frame_start (rd_frame_start),
        .rd_space       (rd_space),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .burst_done     (burst_done),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .wr_burst_cnt   (wr_burst_cnt),
        .rd_burst_cnt   (rd_burst_cnt),
        .busy           (busy)
    );

    typedef struct {
        logic        wr;
        logic [28:0] addr;
    } cmd_t;

    typedef struct {
        logic [9:0]  wl;
        logic [9:0]  rs;
        logic        ew;
        logic [28:0] ea;
    } vec_t;

    cmd_t cmd_q[$];
    int   rd_idx = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   ip_auto;
    int   done_delay;

    // Memory-IP stand-in: accepts a pending command after one cycle, pulses burst_done done_delay cycles later.
    initial begin
        int   cnt;
        cmd_t c;
        cnt = 0;
        cmd_ready = 1'b0;
        burst_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            burst_done = 1'b0;
            if (cmd_ready) begin
                c.wr = cmd_write;
                c.addr = cmd_addr;
                cmd_q.push_back(c);
                cnt = done_delay;
            end
            cmd_ready = ip_auto && cmd_valid;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) burst_done = 1'b1;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && wr_bank == rd_bank) begin
            n_fail++;
            $display("FAIL bank_invariant: wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);
        end
    endtask

    task automatic wait_cmd(input string name, output cmd_t c, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (cmd_q.size() > rd_idx) begin
                c = cmd_q[rd_idx];
                rd_idx++;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no command within 300 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 50 && !idle; k++) begin
            tick();
            idle = !busy && !cmd_valid;
        end
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still busy after 50 cycles", name);
        end
        repeat (3) tick();
    endtask

    task automatic fill_writes(input int target);
        bit hit;
        hit = 1'b0;
        done_delay = 1;
        rd_space = 10'd0;
        wr_level = 10'd32;
        for (int k = 0; k < 20000 && !hit; k++) begin
            tick();
            hit = (int'(wr_burst_cnt) == target);
        end
        wr_level = 10'd0;
        wait_idle("fill_idle");
        check($sformatf("fill_to_%0d", target), 32'(wr_burst_cnt), 32'(target));
        rd_idx = cmd_q.size();
    endtask

    task automatic pulse(input bit w, input bit r);
        wr_frame_start = w;
        rd_frame_start = r;
        tick();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        vec_t vecs[11];
        cmd_t c;
        bit   ok, seen;

        vecs[0]  = '{10'd32, 10'd100, 1'b1, 29'h000_0000};
        vecs[1]  = '{10'd32, 10'd100, 1'b0, 29'h080_0000};
        vecs[2]  = '{10'd32, 10'd100, 1'b1, 29'h000_0100};
        vecs[3]  = '{10'd32, 10'd100, 1'b0, 29'h080_0100};
        vecs[4]  = '{10'd32, 10'd100, 1'b1, 29'h000_0200};
        vecs[5]  = '{10'd32, 10'd100, 1'b0, 29'h080_0200};
        vecs[6]  = '{10'd32, 10'd800, 1'b0, 29'h080_0300};
        vecs[7]  = '{10'd32, 10'd800, 1'b0, 29'h080_0400};
        vecs[8]  = '{10'd32, 10'd800, 1'b0, 29'h080_0500};
        vecs[9]  = '{10'd32, 10'd500, 1'b1, 29'h000_0300};
        vecs[10] = '{10'd32, 10'd500, 1'b0, 29'h080_0600};

        rst = 1'b1;
        calib_done = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_level = 10'd32;
        rd_space = 10'd100;
        ip_auto = 1'b1;
        done_delay = 4;
        repeat (3) tick();
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_write", 32'(cmd_write), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd1);
        check("rst_wr_cnt", 32'(wr_burst_cnt), 32'd0);
        check("rst_rd_cnt", 32'(rd_burst_cnt), 32'd0);

        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (cmd_valid || busy) seen = 1'b1;
        end
        check("no_cmd_before_calib", 32'(seen), 32'd0);

        calib_done = 1'b1;
        tick();
        check("calib_plus1_valid", 32'(cmd_valid), 32'd0);
        tick();
        check("calib_plus2_valid", 32'(cmd_valid), 32'd1);
        check("first_cmd_write", 32'(cmd_write), 32'd1);
        check("first_cmd_addr", 32'(cmd_addr), 32'd0);

        for (int i = 0; i < 11; i++) begin
            wr_level = vecs[i].wl;
            rd_space = vecs[i].rs;
            wait_cmd($sformatf("vec%0d", i), c, ok);
            if (ok) begin
                check($sformatf("vec%0d_write", i), 32'(c.wr), 32'(vecs[i].ew));
                check($sformatf("vec%0d_addr", i), 32'(c.addr), 32'(vecs[i].ea));
            end
        end
        wr_level = 10'd0;
        rd_space = 10'd0;
        wait_idle("vec_idle");
        check("vec_wr_cnt", 32'(wr_burst_cnt), 32'd4);
        check("vec_rd_cnt", 32'(rd_burst_cnt), 32'd7);

        // Incomplete input frame: bank kept, frame restarts at bank base.
        fill_writes(900);
        pulse(1'b1, 1'b0);
        check("partial_wr_bank", 32'(wr_bank), 32'd0);
        check("partial_rd_bank", 32'(rd_bank), 32'd1);
        check("partial_wr_cnt", 32'(wr_burst_cnt), 32'd0);
        wr_level = 10'd32;
        wait_cmd("partial_next", c, ok);
        wr_level = 10'd0;
        if (ok) begin
            check("partial_next_write", 32'(c.wr), 32'd1);
            check("partial_next_addr", 32'(c.addr), 32'd0);
        end
        wait_idle("partial_idle");
        pulse(1'b0, 1'b1);
        check("partial_latest_rd_bank", 32'(rd_bank), 32'd1);
        check("partial_rd_cnt", 32'(rd_burst_cnt), 32'd0);

        // Complete frame, saturation, then swap.
        fill_writes(1800);
        check("full_last_addr", 32'(cmd_q[cmd_q.size()-1].addr), 32'h0007_0700);
        wr_level = 10'd32;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (cmd_valid || busy) seen = 1'b1;
        end
        wr_level = 10'd0;
        check("saturated_no_cmd", 32'(seen), 32'd0);
        check("saturated_cnt", 32'(wr_burst_cnt), 32'd1800);
        pulse(1'b1, 1'b0);
        check("swap_wr_bank", 32'(wr_bank), 32'd2);
        check("swap_wr_cnt", 32'(wr_burst_cnt), 32'd0);
        pulse(1'b0, 1'b1);
        check("swap_rd_bank", 32'(rd_bank), 32'd0);
        check("swap_rd_cnt", 32'(rd_burst_cnt), 32'd0);
        rd_idx = cmd_q.size();
        rd_space = 10'd100;
        wait_cmd("swap_read", c, ok);
        rd_space = 10'd0;
        if (ok) begin
            check("swap_read_write", 32'(c.wr), 32'd0);
            check("swap_read_addr", 32'(c.addr), 32'd0);
        end
        wait_idle("swap_idle");

        // Both frame events while a burst is in WAIT, write frame complete.
        fill_writes(1800);
        check("bank2_last_addr", 32'(cmd_q[cmd_q.size()-1].addr), 32'h0107_0700);
        done_delay = 8;
        rd_space = 10'd100;
        wait_cmd("wait_read", c, ok);
        rd_space = 10'd0;
        if (ok) check("wait_read_addr", 32'(c.addr), 32'h0000_0100);
        wr_frame_start = 1'b1;
        rd_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        check("dual_busy", 32'(busy), 32'd1);
        check("dual_pre_wr_bank", 32'(wr_bank), 32'd2);
        wait_idle("dual_idle");
        check("dual_wr_bank", 32'(wr_bank), 32'd1);
        check("dual_rd_bank", 32'(rd_bank), 32'd2);
        check("dual_wr_cnt", 32'(wr_burst_cnt), 32'd0);
        check("dual_rd_cnt", 32'(rd_burst_cnt), 32'd0);

        // Calibration loss while a command is held in ISSUE.
        ip_auto = 1'b0;
        rd_space = 10'd100;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            seen = cmd_valid;
        end
        check("hold_valid_seen", 32'(seen), 32'd1);
        repeat (3) tick();
        check("hold_valid", 32'(cmd_valid), 32'd1);
        check("hold_addr", 32'(cmd_addr), 32'h0100_0000);
        calib_done = 1'b0;
        tick();
        tick();
        check("calib_loss_valid", 32'(cmd_valid), 32'd0);
        check("calib_loss_busy", 32'(busy), 32'd0);
        check("calib_loss_rd_bank", 32'(rd_bank), 32'd2);
        check("calib_loss_rd_cnt", 32'(rd_burst_cnt), 32'd0);
        rd_idx = cmd_q.size();
        calib_done = 1'b1;
        ip_auto = 1'b1;
        wait_cmd("recal_read", c, ok);
        rd_space = 10'd0;
        if (ok) check("recal_read_addr", 32'(c.addr), 32'h0100_0000);
        wait_idle("recal_idle");
        check("recal_rd_cnt", 32'(rd_burst_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
